// File: rtl/servo_frame_scheduler_pkg.sv
// Shared constants, FSM encoding and width helpers for the servo frame scheduler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package servo_pkg;

    localparam int SERVO_US_W       = 12;
    localparam int DEF_PULSE_MIN_US = 650;
    localparam int DEF_PULSE_MAX_US = 2600;
    localparam int DEF_GUARD_US     = 50;
    localparam int DEF_SLEW_US      = 20;

    // SLOT is a zero-time decision phase: the FSM passes through it inside one
    // cycle and the state register never holds it.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SLOT  = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // Rest position between the clamp limits.
    function automatic int center_us(input int lo, input int hi);
        return (lo + hi) / 2;
    endfunction

    function automatic logic [SERVO_US_W-1:0] clamp_us(
        input logic [SERVO_US_W-1:0] us,
        input logic [SERVO_US_W-1:0] lo,
        input logic [SERVO_US_W-1:0] hi
    );
        if (us < lo) return lo;
        if (us > hi) return hi;
        return us;
    endfunction

    // Move cur toward tgt by at most step; both are already clamped, so the
    // result stays inside [lo, hi] and never wraps.
    function automatic logic [SERVO_US_W-1:0] slew_step(
        input logic [SERVO_US_W-1:0] cur,
        input logic [SERVO_US_W-1:0] tgt,
        input logic [SERVO_US_W-1:0] step
    );
        if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
        return ((cur - tgt) > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_us_tick_gen.sv
// Microsecond tick divider: one-cycle tick every CLK_HZ/1e6 clocks.
// Latency: first tick CLK_HZ/1e6 - 1 cycles after reset release, then periodic.
// Backpressure: none, free running.  Ports: CLK, RST_N in; tick out.
module us_tick_gen #(
    parameter int CLK_HZ = 12_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Time-multiplexes one us pulse timer over N_CH servos in a fixed frame; pulses back-to-back, GUARD_US gap after each.
// Latency: setpoint write lands in target one cycle after acceptance, used at the channel's next slot start.
// Backpressure: set_ready is 1 from the first cycle after reset; one write per cycle, set_ch >= N_CH discarded.
// Ports: CLK, RST_N; set_valid/set_ready/set_ch/set_us write port; ch_enable per-channel enable;
//        servo_out PWM pins; frame_start one-cycle frame marker; active_ch channel in pulse/guard (N_CH idle).
// Option: SERVO_SLEW_LIMIT_EN limits the width change per frame to SLEW_US.
module servo_frame_scheduler
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int N_CH         = 4,
    parameter int FRAME_US     = 20000,
    parameter int PULSE_MIN_US = DEF_PULSE_MIN_US,
    parameter int PULSE_MAX_US = DEF_PULSE_MAX_US,
    parameter int GUARD_US     = DEF_GUARD_US,
    parameter int SLEW_US      = DEF_SLEW_US
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  set_valid,
    output logic                  set_ready,
    input  logic [2:0]            set_ch,
    input  logic [SERVO_US_W-1:0] set_us,
    input  logic [N_CH-1:0]       ch_enable,
    output logic [N_CH-1:0]       servo_out,
    output logic                  frame_start,
    output logic [2:0]            active_ch
);
    localparam int W   = SERVO_US_W;
    localparam int FCW = $clog2(FRAME_US);
    localparam logic [W-1:0]   MIN_W      = W'(PULSE_MIN_US);
    localparam logic [W-1:0]   MAX_W      = W'(PULSE_MAX_US);
    localparam logic [W-1:0]   CENTER_W   = W'(center_us(PULSE_MIN_US, PULSE_MAX_US));
    localparam logic [W-1:0]   GUARD_W    = W'(GUARD_US);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_US - 1);
    localparam logic [2:0]     IDLE_CH    = 3'(N_CH);
`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [W-1:0]   SLEW_W     = W'(SLEW_US);
`endif

    if (N_CH < 1 || N_CH > 8) begin : g_chk_nch
        $error("servo_frame_scheduler: N_CH must be 1..8");
    end
    if (N_CH * (PULSE_MAX_US + GUARD_US) >= FRAME_US) begin : g_chk_frame
        $error("servo_frame_scheduler: channel slots do not fit in the frame");
    end
    if ((CLK_HZ % 1_000_000) != 0 || CLK_HZ < 2_000_000) begin : g_chk_clk
        $error("servo_frame_scheduler: CLK_HZ must be an integer multiple >= 2 of 1 MHz");
    end
    if (GUARD_US < 1 || SLEW_US < 1) begin : g_chk_guard
        $error("servo_frame_scheduler: GUARD_US and SLEW_US must be >= 1");
    end

    logic tick;

    us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick)
    );

    logic [2:0]     state_q, state_d;
    logic [2:0]     ch_q, ch_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [N_CH-1:0] servo_q, servo_d;
    logic           frame_start_q, frame_start_d;
    logic [2:0]     active_ch_q, active_ch_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           set_ready_q, set_ready_d;
    logic [W-1:0]   target_q [N_CH];
    logic [W-1:0]   target_d [N_CH];
    logic [W-1:0]   active_q [N_CH];
    logic [W-1:0]   active_d [N_CH];

    logic           frame_begin;
    logic [3:0]     slot_from;
    logic           found;
    logic [2:0]     sel;
    logic [W-1:0]   new_w;

    // Microsecond 0 of every frame is the tick seen while the counter reads 0.
    assign frame_begin = tick && (frame_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        rem_d         = rem_q;
        servo_d       = servo_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        set_ready_d   = 1'b1;
        target_d      = target_q;
        active_d      = active_q;
        slot_from     = '0;
        found         = 1'b0;
        sel           = '0;
        new_w         = '0;

        if (tick) frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FCW'(1);

        for (int j = 0; j < N_CH; j++) begin
            if (set_valid && set_ready_q && (int'(set_ch) == j))
                target_d[j] = clamp_us(set_us, MIN_W, MAX_W);
        end

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (frame_begin) begin
                    frame_start_d = 1'b1;
                    state_d       = ST_SLOT;
                    slot_from     = '0;
                end
            end
            ST_PULSE: begin
                if (tick) begin
                    if (rem_q == W'(1)) begin
                        servo_d = '0;
                        state_d = ST_GUARD;
                        rem_d   = GUARD_W;
                    end else begin
                        rem_d = rem_q - W'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (tick) begin
                    if (rem_q == W'(1)) begin
                        state_d   = ST_SLOT;
                        slot_from = {1'b0, ch_q} + 4'd1;
                    end else begin
                        rem_d = rem_q - W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Slot resolution: disabled channels are skipped in the same cycle, so
        // the first enabled channel at or after slot_from starts right away.
        // The latch reads target_q, so a write landing this cycle waits a frame.
        if (state_d == ST_SLOT) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!found && (j >= int'(slot_from)) && ch_enable[j]) begin
                    found = 1'b1;
                    sel   = 3'(j);
`ifdef SERVO_SLEW_LIMIT_EN
                    new_w = slew_step(active_q[j], target_q[j], SLEW_W);
`else
                    new_w = target_q[j];
`endif
                    active_d[j] = new_w;
                    servo_d     = '0;
                    servo_d[j]  = 1'b1;
                end
            end
            if (found) begin
                state_d = ST_PULSE;
                ch_d    = sel;
                rem_d   = new_w;
            end else begin
                state_d = ST_WAIT;
            end
        end

        active_ch_d = (state_d == ST_PULSE || state_d == ST_GUARD) ? ch_d : IDLE_CH;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            rem_q         <= '0;
            servo_q       <= '0;
            frame_start_q <= 1'b0;
            active_ch_q   <= IDLE_CH;
            frame_cnt_q   <= '0;
            set_ready_q   <= 1'b0;
            for (int j = 0; j < N_CH; j++) begin
                target_q[j] <= CENTER_W;
                active_q[j] <= CENTER_W;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            rem_q         <= rem_d;
            servo_q       <= servo_d;
            frame_start_q <= frame_start_d;
            active_ch_q   <= active_ch_d;
            frame_cnt_q   <= frame_cnt_d;
            set_ready_q   <= set_ready_d;
            target_q      <= target_d;
            active_q      <= active_d;
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frame_start_q;
    assign active_ch   = active_ch_q;
    assign set_ready   = set_ready_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler at 2 clocks per us and a 10700 us frame.
// Latency: measures pulse widths, guard gaps and frame period in clock cycles.
// Backpressure: writes are single-cycle; set_ready is checked directly.
module tb_servo_frame_scheduler;
    localparam int CPU      = 2;       // clocks per microsecond
    localparam int FRAME_US = 10700;
    localparam int CENTER   = 1625;
`ifdef SERVO_SLEW_LIMIT_EN
    localparam int F1_W1 = 1605, F1_W3 = 1605;
    localparam int F2_W0 = 1645, F2_W1 = 1585, F2_W2 = 1645, F2_W3 = 1585;
`else
    localparam int F1_W1 = 1000, F1_W3 = 650;
    localparam int F2_W0 = 2000, F2_W1 = 1000, F2_W2 = 2600, F2_W3 = 650;
`endif

    logic        CLK;
    logic        RST_N;
    logic        set_valid;
    logic        set_ready;
    logic [2:0]  set_ch;
    logic [11:0] set_us;
    logic [3:0]  ch_enable;
    logic [3:0]  servo_out;
    logic        frame_start;
    logic [2:0]  active_ch;

    servo_frame_scheduler #(
        .CLK_HZ   (2_000_000),
        .N_CH     (4),
        .FRAME_US (FRAME_US)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .set_valid   (set_valid),
        .set_ready   (set_ready),
        .set_ch      (set_ch),
        .set_us      (set_us),
        .ch_enable   (ch_enable),
        .servo_out   (servo_out),
        .frame_start (frame_start),
        .active_ch   (active_ch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    int multi_hi = 0;
    int n_chk = 0;
    int n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if ($countones(servo_out) > 1) multi_hi <= multi_hi + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_pat(input logic [3:0] pat, output int t);
        int n = 0;
        while (servo_out != pat && n < 8000) begin
            @(negedge CLK);
            n++;
        end
        if (servo_out != pat) check_eq("wait_servo_out", int'(servo_out), int'(pat));
        t = cyc;
    endtask

    task automatic wait_any(output int t);
        int n = 0;
        while (servo_out == 4'b0 && n < 8000) begin
            @(negedge CLK);
            n++;
        end
        if (servo_out == 4'b0) check_eq("wait_any_high", 0, 1);
        t = cyc;
    endtask

    task automatic wait_fs(output int t);
        int n = 0;
        while (frame_start != 1'b1 && n < 25000) begin
            @(negedge CLK);
            n++;
        end
        if (frame_start != 1'b1) check_eq("wait_frame_start", 0, 1);
        t = cyc;
    endtask

    task automatic write_sp(input int ch, input int us);
        set_valid = 1'b1;
        set_ch    = 3'(ch);
        set_us    = 12'(us);
        @(negedge CLK);
        set_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, t3, tr, tf;
        RST_N = 1'b0; set_valid = 1'b0; set_ch = '0; set_us = '0; ch_enable = 4'hF;
        repeat (3) @(negedge CLK);
        check_eq("rst_servo_out", int'(servo_out), 0);
        check_eq("rst_frame_start", int'(frame_start), 0);
        check_eq("rst_active_ch", int'(active_ch), 4);
        check_eq("rst_set_ready", int'(set_ready), 0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_eq("set_ready_up", int'(set_ready), 1);

        // Frame 0: defaults on every channel; writes posted during pulses.
        wait_fs(t0);
        check_eq("f0_start_out", int'(servo_out), 4'b0001);
        check_eq("f0_active_ch", int'(active_ch), 0);
        @(negedge CLK);
        check_eq("fs_one_cycle", int'(frame_start), 0);
        repeat (9) @(negedge CLK);
        write_sp(0, 2000);
        wait_pat(4'b0000, tf);
        check_eq("f0_w0", tf - t0, CENTER * CPU);
        wait_pat(4'b0010, tr);
        check_eq("f0_guard", tr - tf, 50 * CPU);
        wait_pat(4'b0000, tf);
        check_eq("f0_w1", tf - tr, CENTER * CPU);
        wait_pat(4'b0100, tr);
        write_sp(1, 1000);
        write_sp(2, 4000);
        write_sp(5, 700);
        wait_pat(4'b0000, tf);
        check_eq("f0_w2", tf - tr, CENTER * CPU);
        wait_pat(4'b1000, tr);
        write_sp(3, 0);
        wait_pat(4'b0000, tf);
        check_eq("f0_w3", tf - tr, CENTER * CPU);
        repeat (101) @(negedge CLK);
        check_eq("wait_active_ch", int'(active_ch), 4);
        ch_enable = 4'b1010;

        // Frame 1: only ch1 and ch3 enabled.
        wait_fs(t1);
        check_eq("period_0", t1 - t0, FRAME_US * CPU);
        check_eq("f1_skip_ch0", int'(servo_out), 4'b0010);
        wait_pat(4'b0000, tf);
        check_eq("f1_w1", tf - t1, F1_W1 * CPU);
        wait_any(tr);
        check_eq("f1_next_is_ch3", int'(servo_out), 4'b1000);
        check_eq("f1_gap_ch1_ch3", tr - tf, 50 * CPU);
        wait_pat(4'b0000, tf);
        check_eq("f1_w3", tf - tr, F1_W3 * CPU);
        ch_enable = 4'hF;

        // Frame 2: all enabled, new widths.
        wait_fs(t2);
        check_eq("period_1", t2 - t1, FRAME_US * CPU);
        wait_pat(4'b0000, tf);
        check_eq("f2_w0", tf - t2, F2_W0 * CPU);
        wait_pat(4'b0010, tr);
        wait_pat(4'b0000, tf);
        check_eq("f2_w1", tf - tr, F2_W1 * CPU);
        wait_pat(4'b0100, tr);
        wait_pat(4'b0000, tf);
        check_eq("f2_w2_clamped", tf - tr, F2_W2 * CPU);
        wait_pat(4'b1000, tr);
        wait_pat(4'b0000, tf);
        check_eq("f2_w3_clamped", tf - tr, F2_W3 * CPU);

        // Frame 3: reset in the middle of ch2's pulse.
        wait_fs(t3);
        check_eq("period_2", t3 - t2, FRAME_US * CPU);
        wait_pat(4'b0000, tf);
        wait_pat(4'b0010, tr);
        wait_pat(4'b0000, tf);
        wait_pat(4'b0100, tr);
        repeat (200) @(negedge CLK);
        check_eq("f3_mid_ch2", int'(servo_out), 4'b0100);
        check_eq("f3_mid_active", int'(active_ch), 2);
        RST_N = 1'b0;
        #1;
        check_eq("async_rst_out", int'(servo_out), 0);
        check_eq("async_rst_ach", int'(active_ch), 4);
        check_eq("async_rst_ready", int'(set_ready), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_fs(t0);
        wait_pat(4'b0000, tf);
        check_eq("post_rst_w0", tf - t0, CENTER * CPU);
        wait_pat(4'b0010, tr);
        wait_pat(4'b0000, tf);
        check_eq("post_rst_w1", tf - tr, CENTER * CPU);

        check_eq("one_hot", multi_hi, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
